external_bus_to_avalon_master_bridge: RTL and testbench
=======================================================

Name: external_bus_to_avalon_master_bridge

Overview:
- Responder (target) end of the team's simple external bus: address / bus_enable / byte_enable / rw / write_data in, acknowledge / read_data out.
- Decodes the bus address window and converts each bus access into a single Avalon-MM master transfer with waitrequest flow control.
- Returns a one-cycle acknowledge carrying the read data.
- Sits between the external-bus initiator bridge and an Avalon slave (SRAM controller, peripheral register file).

Parameters:
- ADDR_BITS, 18, Avalon word-address width.
- DATA_BITS, 16, data width on both sides.
- ADDR_LOW, 1, byte-offset bits dropped from the bus address (log2 of bytes per word).
- BYTE_EN_BITS, 2, byte-enable width (DATA_BITS/8).
- TIMEOUT_CYCLES, 200, maximum Avalon wait cycles before abort. Legal range 1..254; must stay below the initiator's 255-cycle timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- address  in  32  bus byte address
- bus_enable  in  1  initiator access request level
- byte_enable  in  BYTE_EN_BITS  bus byte lanes
- rw  in  1  1 = read, 0 = write
- write_data  in  DATA_BITS  bus write data
- acknowledge  out  1  one-cycle completion pulse
- read_data  out  DATA_BITS  read return data
- avm_address  out  ADDR_BITS  Avalon word address
- avm_byteenable  out  BYTE_EN_BITS  Avalon byte enables
- avm_read  out  1  Avalon read strobe
- avm_write  out  1  Avalon write strobe
- avm_writedata  out  DATA_BITS  Avalon write data
- avm_readdata  in  DATA_BITS  Avalon read data; valid when avm_waitrequest = 0 during a read
- avm_waitrequest  in  1  Avalon stall
- timeout_error  out  1  one-cycle pulse, coincident with acknowledge, on an aborted access

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk. All outputs are registered.
- Reset values: acknowledge=0, read_data=0, avm_*=0, timeout_error=0, state=IDLE, wait counter=0.
- Reset asserted mid-transfer: strobes drop at the next edge; no acknowledge is issued.
- Window hit: address[31:ADDR_BITS+ADDR_LOW] == 0. A miss is never acknowledged. The initiator drives the upper bits to all ones when idle, so its idle toggling of bus_enable is ignored.
- FSM states: IDLE, ACCESS, ACK, RELEASE.
- IDLE, on bus_enable=1 and window hit:
  - Latch avm_address = address[ADDR_BITS+ADDR_LOW-1:ADDR_LOW], avm_byteenable = byte_enable, avm_writedata = write_data.
  - Set avm_read = rw and avm_write = ~rw at the next edge; go to ACCESS.
  - Exception: if rw=0 and byte_enable=0, issue no Avalon write and go directly to ACK.
- ACCESS: strobe, address, byteenable and writedata are held stable while avm_waitrequest=1; the wait counter increments each cycle.
  - avm_waitrequest=0: drop the strobe at the edge. On a read, load read_data <= avm_readdata. Go to ACK.
  - Counter reaches TIMEOUT_CYCLES with waitrequest still 1: drop the strobe, read_data <= all ones (reads only), arm timeout_error, go to ACK.
  - Completion and timeout in the same cycle: completion wins.
- ACK: acknowledge=1 for exactly one cycle (plus timeout_error if armed); clear the counter; go to RELEASE.
- RELEASE: wait for bus_enable=0 or a window miss, then go to IDLE. This prevents a still-high bus_enable from re-triggering the same access.
- Latency: bus_enable sampled in IDLE at cycle t, then avm strobe at t+1. With zero wait states, acknowledge at t+2; each wait state adds one cycle.
- read_data is unchanged by writes and holds until the next read completion or timeout.
- Changes on bus inputs after capture are ignored until the next IDLE.
- Back-to-back: the initiator drops bus_enable the cycle after acknowledge. A new request is accepted no earlier than the second cycle after acknowledge.

Test Plan:
- Reset, then idle bus with address=0xFFFC0000 and bus_enable toggling -> no avm strobe, acknowledge stays 0, all outputs 0.
- Read addr 0x00000246, be=2'b11, waitrequest=0, avm_readdata=0xBEEF -> avm_read at t+1 with avm_address=0x123; acknowledge at t+2 with read_data=0xBEEF.
- Write addr 0x00000010, data 0x5A5A, be=2'b01, waitrequest high 3 cycles -> avm_write held 4 cycles with avm_address=0x008, avm_byteenable=01; single ack at t+5; read_data unchanged.
- Read with waitrequest stuck high -> strobe drops after 200 wait cycles; acknowledge and timeout_error pulse together with read_data=0xFFFF.
- Write with be=0 -> no avm_write; acknowledge at t+1.
- Reset during ACCESS (wait state) -> avm_read=0 next edge, no acknowledge. Next read afterwards completes normally.

Source files
------------

// File: rtl/external_bus_to_avalon_master_bridge.sv
// external_bus_to_avalon_master_bridge: external-bus responder that turns each windowed access
// into one Avalon-MM master transfer and returns a one-cycle acknowledge with read data.
module external_bus_to_avalon_master_bridge #(
    parameter int ADDR_BITS      = 18,
    parameter int DATA_BITS      = 16,
    parameter int ADDR_LOW       = 1,
    parameter int BYTE_EN_BITS   = 2,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             address,
    input  logic                    bus_enable,
    input  logic [BYTE_EN_BITS-1:0] byte_enable,
    input  logic                    rw,
    input  logic [DATA_BITS-1:0]    write_data,
    output logic                    acknowledge,
    output logic [DATA_BITS-1:0]    read_data,
    output logic [ADDR_BITS-1:0]    avm_address,
    output logic [BYTE_EN_BITS-1:0] avm_byteenable,
    output logic                    avm_read,
    output logic                    avm_write,
    output logic [DATA_BITS-1:0]    avm_writedata,
    input  logic [DATA_BITS-1:0]    avm_readdata,
    input  logic                    avm_waitrequest,
    output logic                    timeout_error
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_t;
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t                  r_state, w_state_n;
    logic [7:0]              r_cnt, w_cnt_n;
    logic                    r_ack, w_ack_n, r_to, w_to_n, r_read, w_read_n, r_write, w_write_n;
    logic [DATA_BITS-1:0]    r_rdata, w_rdata_n, r_wdata, w_wdata_n;
    logic [ADDR_BITS-1:0]    r_addr, w_addr_n;
    logic [BYTE_EN_BITS-1:0] r_be, w_be_n;
    logic                    w_hit;
    logic                    w_unused_lsb;

    assign w_hit        = address[31:ADDR_BITS+ADDR_LOW] == '0;
    assign w_unused_lsb = &{1'b0, address[ADDR_LOW-1:0]};

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_ack_n   = 1'b0;
        w_to_n    = 1'b0;
        w_read_n  = r_read;
        w_write_n = r_write;
        w_rdata_n = r_rdata;
        w_wdata_n = r_wdata;
        w_addr_n  = r_addr;
        w_be_n    = r_be;
        case (r_state)
            IDLE: if (bus_enable && w_hit) begin
                w_addr_n  = address[ADDR_BITS+ADDR_LOW-1:ADDR_LOW];
                w_be_n    = byte_enable;
                w_wdata_n = write_data;
                // A write with no byte lanes has nothing to do on Avalon; acknowledge it directly.
                if (!rw && byte_enable == '0) begin
                    w_ack_n   = 1'b1;
                    w_state_n = ACK;
                end else begin
                    w_read_n  = rw;
                    w_write_n = ~rw;
                    w_state_n = ACCESS;
                end
            end
            ACCESS: if (!avm_waitrequest) begin
                w_read_n  = 1'b0;
                w_write_n = 1'b0;
                w_rdata_n = r_read ? avm_readdata : r_rdata;
                w_ack_n   = 1'b1;
                w_state_n = ACK;
            end else if (r_cnt == LAST_WAIT) begin
                w_read_n  = 1'b0;
                w_write_n = 1'b0;
                w_rdata_n = r_read ? '1 : r_rdata;
                w_ack_n   = 1'b1;
                w_to_n    = 1'b1;
                w_state_n = ACK;
            end else begin
                w_cnt_n = r_cnt + 8'd1;
            end
            ACK: begin
                w_cnt_n   = '0;
                w_state_n = RELEASE;
            end
            RELEASE: w_state_n = (!bus_enable || !w_hit) ? IDLE : RELEASE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_to    <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_ack   <= w_ack_n;
            r_to    <= w_to_n;
            r_read  <= w_read_n;
            r_write <= w_write_n;
            r_rdata <= w_rdata_n;
            r_wdata <= w_wdata_n;
            r_addr  <= w_addr_n;
            r_be    <= w_be_n;
        end
    end

    assign acknowledge    = r_ack;
    assign timeout_error  = r_to;
    assign read_data      = r_rdata;
    assign avm_address    = r_addr;
    assign avm_byteenable = r_be;
    assign avm_read       = r_read;
    assign avm_write      = r_write;
    assign avm_writedata  = r_wdata;
endmodule

// File: tb/tb_external_bus_to_avalon_master_bridge.sv
// tb_external_bus_to_avalon_master_bridge: directed and randomized bus accesses checked against
// a transaction-level model of latency, strobe length, timeout and read-data behaviour.
module tb_external_bus_to_avalon_master_bridge;
    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        bus_enable;
    logic [1:0]  byte_enable;
    logic        rw;
    logic [15:0] write_data;
    logic        acknowledge;
    logic [15:0] read_data;
    logic [17:0] avm_address;
    logic [1:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        avm_waitrequest;
    logic        timeout_error;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [15:0] rd_model = '0;

    external_bus_to_avalon_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .address(address), .bus_enable(bus_enable),
        .byte_enable(byte_enable), .rw(rw), .write_data(write_data),
        .acknowledge(acknowledge), .read_data(read_data), .avm_address(avm_address),
        .avm_byteenable(avm_byteenable), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic quiet();
        return !acknowledge && !avm_read && !avm_write && !timeout_error;
    endfunction

    task automatic access(input logic [31:0] addr, input logic [1:0] be, input logic rd,
                          input logic [15:0] wd, input int nwait, input logic [15:0] rdat);
        int   ack_at = -1;
        int   scnt = 0;
        int   exp_s, exp_ack, hold;
        bit   nowr, stable = 1, still = 1, to_seen = 0;
        logic [15:0] rd_seen = '0;
        nowr    = !rd && be == 2'b00;
        exp_s   = nowr ? 0 : (nwait >= TO ? TO : nwait + 1);
        exp_ack = nowr ? 1 : exp_s + 1;
        address = addr; bus_enable = 1'b1; byte_enable = be; rw = rd; write_data = wd;
        avm_waitrequest = 1'b1; avm_readdata = 16'($urandom);
        for (int c = 1; c <= TO + 10 && ack_at < 0; c++) begin
            @(posedge clk); #1;
            if (avm_read || avm_write) begin
                scnt++;
                if (avm_address != addr[18:1] || avm_byteenable != be || avm_read != rd ||
                    avm_write != !rd || avm_writedata != wd) stable = 0;
            end
            if (acknowledge) begin
                ack_at = c; to_seen = timeout_error; rd_seen = read_data;
            end else if (timeout_error) stable = 0;
            avm_waitrequest = scnt <= nwait;
            avm_readdata    = avm_waitrequest ? 16'($urandom) : rdat;
            if (ack_at < 0) begin
                address = $urandom & 32'h0007_FFFF; write_data = 16'($urandom);
                byte_enable = 2'($urandom); rw = 1'($urandom);
            end
        end
        if (rd) rd_model = nwait >= TO ? 16'hFFFF : rdat;
        chk("ack_cycle", ack_at, exp_ack);
        chk("strobe_len", scnt, exp_s);
        chk("strobe_fields", stable, 1);
        chk("timeout_err", to_seen, !nowr && nwait >= TO);
        chk("read_data", rd_seen, rd_model);
        address = addr;
        hold = $urandom_range(0, 2);
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
            if (!quiet()) still = 0;
        end
        bus_enable = 1'b0; address = 32'hFFFC_0000;
        @(posedge clk); #1;
        if (!quiet()) still = 0;
        chk("release_quiet", still, 1);
    endtask

    initial begin
        bit ok;
        reset = 1'b1; address = 32'hFFFC_0000; bus_enable = 1'b0; byte_enable = '0; rw = 1'b0;
        write_data = '0; avm_readdata = '0; avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {acknowledge, read_data, avm_address, avm_byteenable, avm_read,
                              avm_write, avm_writedata, timeout_error}, 0);
        reset = 1'b0;
        ok = 1;
        for (int i = 0; i < 12; i++) begin
            bus_enable = ~bus_enable;
            address = i < 6 ? 32'hFFFC_0000 : 32'h0008_0000;
            @(posedge clk); #1;
            if ({acknowledge, read_data, avm_address, avm_byteenable, avm_read, avm_write,
                 avm_writedata, timeout_error} != 0) ok = 0;
        end
        chk("idle_and_miss", ok, 1);
        bus_enable = 1'b0; address = 32'hFFFC_0000;
        @(posedge clk); #1;

        access(32'h0000_0246, 2'b11, 1'b1, 16'h0000, 0, 16'hBEEF);
        access(32'h0000_0010, 2'b01, 1'b0, 16'h5A5A, 3, 16'h1234);
        access(32'h0000_0100, 2'b11, 1'b1, 16'h0000, 1000, 16'h1111);
        access(32'h0000_0020, 2'b00, 1'b0, 16'h7777, 0, 16'h2222);
        access(32'h0000_0030, 2'b10, 1'b1, 16'h0000, TO - 1, 16'hC0DE);

        address = 32'h0000_0400; bus_enable = 1'b1; byte_enable = 2'b11; rw = 1'b1;
        avm_waitrequest = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_read", avm_read, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_mid_strobe", {avm_read, avm_write, acknowledge, read_data}, 0);
        reset = 1'b0; bus_enable = 1'b0; address = 32'hFFFC_0000;
        rd_model = '0;
        ok = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!quiet()) ok = 0;
        end
        chk("reset_no_ack", ok, 1);
        access(32'h0000_0400, 2'b11, 1'b1, 16'h0000, 2, 16'hA55A);

        for (int n = 0; n < 40; n++) begin
            int nw;
            nw = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 6);
            access($urandom & 32'h0007_FFFF, 2'($urandom), 1'($urandom), 16'($urandom), nw,
                   16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
